// File: rtl/iprefetch_ctrl.sv
// Next-line instruction prefetch controller.
// Sits between the I-cache miss port and the memory arbiter. A one-line buffer
// holds the most recently prefetched line. An I-cache miss that hits the buffer
// is served from it. Any other miss is forwarded to the arbiter's demand port.
// After each demand line is served, the controller queues a prefetch of the
// sequentially next line.

module iprefetch_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned OFF_BITS  = 5,
  parameter int unsigned PF_ENABLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache miss port
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_address,
  output logic              ic_resp,
  output logic [LINE_W-1:0] ic_rdata,
  // Arbiter demand port
  output logic              arb_read,
  output logic [ADDR_W-1:0] arb_address,
  input  logic              arb_resp,
  input  logic [LINE_W-1:0] arb_rdata,
  // Arbiter prefetch port (shares arb_rdata)
  output logic              pf_req,
  output logic [ADDR_W-1:0] pf_addr,
  input  logic              pf_done,
  // Statistics
  output logic [31:0]       pf_hits,
  output logic [31:0]       dmd_misses
);

  localparam int unsigned TagW = ADDR_W - OFF_BITS;
  localparam logic [ADDR_W-1:0] LineInc = ADDR_W'(1) << OFF_BITS;
  localparam bit PfOn = (PF_ENABLE != 0);

  typedef enum logic [1:0] {
    StIdle,
    StHit,
    StDemand,
    StPrefetch
  } state_e;

  state_e              state_q, state_d;
  logic                buf_valid_q, buf_valid_d;
  logic [TagW-1:0]     buf_tag_q, buf_tag_d;
  logic [LINE_W-1:0]   buf_data_q, buf_data_d;
  logic                pf_pending_q, pf_pending_d;
  logic [ADDR_W-1:0]   pf_target_q, pf_target_d;
  logic [TagW-1:0]     req_tag_q, req_tag_d;
  logic [31:0]         pf_hits_q, pf_hits_d;
  logic [31:0]         dmd_misses_q, dmd_misses_d;

  logic [TagW-1:0]     ic_tag;
  logic                buf_hit;
  logic [ADDR_W-1:0]   line_addr;
  logic [ADDR_W-1:0]   next_line;
  logic                next_dup;
  logic                unused_offset;

  // Tag compare and next-line address arithmetic (wraps modulo 2^ADDR_W).
  always_comb begin
    ic_tag    = ic_address[ADDR_W-1:OFF_BITS];
    buf_hit   = buf_valid_q && (buf_tag_q == ic_tag);
    line_addr = {req_tag_q, {OFF_BITS{1'b0}}};
    next_line = line_addr + LineInc;
    next_dup  = buf_valid_q && (buf_tag_q == next_line[ADDR_W-1:OFF_BITS]);
  end

  // Offset bits never take part in any decision.
  assign unused_offset = ^ic_address[OFF_BITS-1:0];

  // Next-state logic and all handshake outputs.
  always_comb begin
    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    buf_tag_d    = buf_tag_q;
    buf_data_d   = buf_data_q;
    pf_pending_d = pf_pending_q;
    pf_target_d  = pf_target_q;
    req_tag_d    = req_tag_q;
    pf_hits_d    = pf_hits_q;
    dmd_misses_d = dmd_misses_q;

    ic_resp     = 1'b0;
    ic_rdata    = '0;
    arb_read    = 1'b0;
    arb_address = '0;
    pf_req      = 1'b0;
    pf_addr     = '0;

    unique case (state_q)
      StIdle: begin
        // A demand always takes priority over a pending prefetch.
        if (ic_read) begin
          req_tag_d = ic_tag;
          if (buf_hit) begin
            state_d = StHit;
          end else begin
            state_d = StDemand;
            if (dmd_misses_q != 32'hFFFF_FFFF) begin
              dmd_misses_d = dmd_misses_q + 32'd1;
            end
          end
        end else if (pf_pending_q && PfOn) begin
          state_d = StPrefetch;
        end
      end

      StHit: begin
        ic_resp  = 1'b1;
        ic_rdata = buf_data_q;
        if (pf_hits_q != 32'hFFFF_FFFF) begin
          pf_hits_d = pf_hits_q + 32'd1;
        end
        // A newer target replaces any one still pending.
        pf_target_d  = next_line;
        pf_pending_d = PfOn && !next_dup;
        state_d      = StIdle;
      end

      StDemand: begin
        arb_read    = 1'b1;
        arb_address = line_addr;
        if (arb_resp) begin
          ic_resp      = 1'b1;
          ic_rdata     = arb_rdata;
          pf_target_d  = next_line;
          pf_pending_d = PfOn && !next_dup;
          state_d      = StIdle;
        end
      end

      StPrefetch: begin
        // The arbiter has committed, so a prefetch always runs to pf_done.
        pf_req  = PfOn;
        pf_addr = pf_target_q;
        if (pf_done) begin
          buf_data_d   = arb_rdata;
          buf_tag_d    = pf_target_q[ADDR_W-1:OFF_BITS];
          buf_valid_d  = PfOn;
          pf_pending_d = 1'b0;
          state_d      = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and buffer registers; synchronous reset invalidates the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      buf_valid_q  <= 1'b0;
      buf_tag_q    <= '0;
      buf_data_q   <= '0;
      pf_pending_q <= 1'b0;
      pf_target_q  <= '0;
      req_tag_q    <= '0;
      pf_hits_q    <= '0;
      dmd_misses_q <= '0;
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      buf_tag_q    <= buf_tag_d;
      buf_data_q   <= buf_data_d;
      pf_pending_q <= pf_pending_d;
      pf_target_q  <= pf_target_d;
      req_tag_q    <= req_tag_d;
      pf_hits_q    <= pf_hits_d;
      dmd_misses_q <= dmd_misses_d;
    end
  end

  assign pf_hits    = pf_hits_q;
  assign dmd_misses = dmd_misses_q;

  // The two arbiter ports must never be requested at once.
  a_excl_req: assert property (@(posedge clk) disable iff (rst) !(arb_read && pf_req));

endmodule

// File: tb/tb_iprefetch_ctrl.sv
// Directed self-checking bench for iprefetch_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_iprefetch_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ic_read = 1'b0;
  logic [31:0]  ic_address = '0;
  logic         ic_resp;
  logic [255:0] ic_rdata;
  logic         arb_read;
  logic [31:0]  arb_address;
  logic         arb_resp = 1'b0;
  logic [255:0] arb_rdata = '0;
  logic         pf_req;
  logic [31:0]  pf_addr;
  logic         pf_done = 1'b0;
  logic [31:0]  pf_hits;
  logic [31:0]  dmd_misses;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [255:0] D1 = {8{32'hA5A5_0001}};
  localparam logic [255:0] D2 = {8{32'h5A5A_0002}};
  localparam logic [255:0] D3 = {8{32'hC3C3_0003}};
  localparam logic [255:0] D4 = {8{32'h3C3C_0004}};
  localparam logic [255:0] D5 = {8{32'h9696_0005}};

  always #5 clk = ~clk;

  iprefetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ic_read     (ic_read),
    .ic_address  (ic_address),
    .ic_resp     (ic_resp),
    .ic_rdata    (ic_rdata),
    .arb_read    (arb_read),
    .arb_address (arb_address),
    .arb_resp    (arb_resp),
    .arb_rdata   (arb_rdata),
    .pf_req      (pf_req),
    .pf_addr     (pf_addr),
    .pf_done     (pf_done),
    .pf_hits     (pf_hits),
    .dmd_misses  (dmd_misses)
  );

  task automatic do_reset();
    rst = 1'b1;
    ic_read = 1'b0; arb_resp = 1'b0; pf_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Demand miss answered at once; ends in the first PREFETCH cycle.
  task automatic do_miss(input logic [31:0] a, input logic [255:0] d);
    ic_read = 1'b1; ic_address = a;
    @(negedge clk);
    arb_resp = 1'b1; arb_rdata = d;
    @(negedge clk);
    arb_resp = 1'b0; ic_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_fill(input logic [255:0] d);
    pf_done = 1'b1; arb_rdata = d;
    @(negedge clk);
    pf_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (ic_resp !== 1'b0) begin n_fail++; $display("FAIL reset_ic_resp got %0b want 0", ic_resp); end
    n_tests++; if (arb_read !== 1'b0 || pf_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_reqs got arb_read=%0b pf_req=%0b want 0 0", arb_read, pf_req);
    end
    n_tests++; if (arb_address !== 32'h0 || pf_addr !== 32'h0 || ic_rdata !== 256'h0) begin
      n_fail++; $display("FAIL reset_data got arb_address=%h pf_addr=%h want 0", arb_address, pf_addr);
    end
    n_tests++; if (pf_hits !== 32'h0 || dmd_misses !== 32'h0) begin
      n_fail++; $display("FAIL reset_counters got %h %h want 0 0", pf_hits, dmd_misses);
    end
  endtask

  task automatic test_cold_miss();
    ic_read = 1'b1; ic_address = 32'h0000_1044;
    @(negedge clk);
    n_tests++; if (arb_read !== 1'b1 || arb_address !== 32'h0000_1040) begin
      n_fail++; $display("FAIL cold_arb got arb_read=%0b addr=%h want 1 00001040", arb_read, arb_address);
    end
    n_tests++; if (dmd_misses !== 32'd1) begin n_fail++; $display("FAIL cold_dmd_misses got %0d want 1", dmd_misses); end
    repeat (9) @(negedge clk);
    n_tests++; if (arb_read !== 1'b1 || ic_resp !== 1'b0 || pf_req !== 1'b0) begin
      n_fail++; $display("FAIL cold_hold got arb_read=%0b ic_resp=%0b pf_req=%0b want 1 0 0", arb_read, ic_resp, pf_req);
    end
    arb_resp = 1'b1; arb_rdata = D1;
    #1;
    n_tests++; if (ic_resp !== 1'b1 || ic_rdata !== D1) begin
      n_fail++; $display("FAIL cold_resp got ic_resp=%0b data=%h want 1 %h", ic_resp, ic_rdata, D1);
    end
    @(negedge clk);
    arb_resp = 1'b0; ic_read = 1'b0;
    n_tests++; if (arb_read !== 1'b0 || ic_resp !== 1'b0) begin
      n_fail++; $display("FAIL cold_release got arb_read=%0b ic_resp=%0b want 0 0", arb_read, ic_resp);
    end
    @(negedge clk);
    n_tests++; if (pf_req !== 1'b1 || pf_addr !== 32'h0000_1060 || arb_read !== 1'b0) begin
      n_fail++; $display("FAIL cold_pf got pf_req=%0b pf_addr=%h want 1 00001060", pf_req, pf_addr);
    end
    n_tests++; if (dmd_misses !== 32'd1) begin n_fail++; $display("FAIL cold_dmd_final got %0d want 1", dmd_misses); end
  endtask

  // Continues from the PREFETCH of 0x1060 left by test_cold_miss.
  task automatic test_seq_hit();
    repeat (2) @(negedge clk);
    n_tests++; if (pf_req !== 1'b1 || pf_addr !== 32'h0000_1060) begin
      n_fail++; $display("FAIL seq_pf_hold got pf_req=%0b pf_addr=%h want 1 00001060", pf_req, pf_addr);
    end
    do_fill(D2);
    n_tests++; if (pf_req !== 1'b0) begin n_fail++; $display("FAIL seq_pf_drop got %0b want 0", pf_req); end
    ic_read = 1'b1; ic_address = 32'h0000_1068;
    @(negedge clk);
    n_tests++; if (ic_resp !== 1'b1 || ic_rdata !== D2 || arb_read !== 1'b0) begin
      n_fail++; $display("FAIL seq_hit got ic_resp=%0b arb_read=%0b data=%h want 1 0 %h", ic_resp, arb_read, ic_rdata, D2);
    end
    ic_read = 1'b0;
    @(negedge clk);
    n_tests++; if (pf_hits !== 32'd1 || dmd_misses !== 32'd1) begin
      n_fail++; $display("FAIL seq_counters got hits=%0d misses=%0d want 1 1", pf_hits, dmd_misses);
    end
    @(negedge clk);
    n_tests++; if (pf_req !== 1'b1 || pf_addr !== 32'h0000_1080) begin
      n_fail++; $display("FAIL seq_next_pf got pf_req=%0b pf_addr=%h want 1 00001080", pf_req, pf_addr);
    end
    do_fill(D3);
  endtask

  task automatic test_collision();
    do_reset();
    do_miss(32'h0000_1044, D1);
    ic_read = 1'b1; ic_address = 32'h0000_1060;
    repeat (3) @(negedge clk);
    n_tests++; if (arb_read !== 1'b0 || ic_resp !== 1'b0 || pf_req !== 1'b1) begin
      n_fail++; $display("FAIL coll_wait got arb_read=%0b ic_resp=%0b pf_req=%0b want 0 0 1", arb_read, ic_resp, pf_req);
    end
    do_fill(D4);
    n_tests++; if (ic_resp !== 1'b0 || arb_read !== 1'b0) begin
      n_fail++; $display("FAIL coll_gap got ic_resp=%0b arb_read=%0b want 0 0", ic_resp, arb_read);
    end
    @(negedge clk);
    n_tests++; if (ic_resp !== 1'b1 || ic_rdata !== D4 || arb_read !== 1'b0) begin
      n_fail++; $display("FAIL coll_hit got ic_resp=%0b arb_read=%0b data=%h want 1 0 %h", ic_resp, arb_read, ic_rdata, D4);
    end
    ic_read = 1'b0;
    @(negedge clk);
    n_tests++; if (pf_hits !== 32'd1 || dmd_misses !== 32'd1) begin
      n_fail++; $display("FAIL coll_counters got hits=%0d misses=%0d want 1 1", pf_hits, dmd_misses);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ic_read = 1'b1; ic_address = 32'hFFFF_FFF0;
    @(negedge clk);
    n_tests++; if (arb_read !== 1'b1 || arb_address !== 32'hFFFF_FFE0) begin
      n_fail++; $display("FAIL wrap_arb got arb_read=%0b addr=%h want 1 ffffffe0", arb_read, arb_address);
    end
    arb_resp = 1'b1; arb_rdata = D5;
    @(negedge clk);
    arb_resp = 1'b0; ic_read = 1'b0;
    @(negedge clk);
    n_tests++; if (pf_req !== 1'b1 || pf_addr !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_pf got pf_req=%0b pf_addr=%h want 1 00000000", pf_req, pf_addr);
    end
  endtask

  task automatic test_reset_mid_prefetch();
    do_reset();
    do_miss(32'h0000_1044, D1);
    do_fill(D2);
    ic_read = 1'b1; ic_address = 32'h0000_1068;
    @(negedge clk);
    ic_read = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (pf_req !== 1'b1 || pf_addr !== 32'h0000_1080) begin
      n_fail++; $display("FAIL rstpf_pre got pf_req=%0b pf_addr=%h want 1 00001080", pf_req, pf_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (pf_req !== 1'b0 || arb_read !== 1'b0 || pf_hits !== 32'd0) begin
      n_fail++; $display("FAIL rstpf_idle got pf_req=%0b arb_read=%0b hits=%0d want 0 0 0", pf_req, arb_read, pf_hits);
    end
    // Line 0x1060 was buffered before reset; it must now miss.
    ic_read = 1'b1; ic_address = 32'h0000_1060;
    @(negedge clk);
    n_tests++; if (arb_read !== 1'b1 || arb_address !== 32'h0000_1060 || ic_resp !== 1'b0) begin
      n_fail++; $display("FAIL rstpf_miss got arb_read=%0b addr=%h ic_resp=%0b want 1 00001060 0", arb_read, arb_address, ic_resp);
    end
    arb_resp = 1'b1; arb_rdata = D3;
    @(negedge clk);
    arb_resp = 1'b0; ic_read = 1'b0;
    @(negedge clk);
    do_fill(D5);
  endtask

  // Buffer now holds line 0x1080 with data D5.
  task automatic test_saturation();
    force dut.pf_hits_q = 32'hFFFF_FFFF;
    #1;
    release dut.pf_hits_q;
    n_tests++; if (pf_hits !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sat_preload got %h want ffffffff", pf_hits);
    end
    ic_read = 1'b1; ic_address = 32'h0000_1084;
    @(negedge clk);
    n_tests++; if (ic_resp !== 1'b1 || ic_rdata !== D5) begin
      n_fail++; $display("FAIL sat_hit got ic_resp=%0b data=%h want 1 %h", ic_resp, ic_rdata, D5);
    end
    ic_read = 1'b0;
    @(negedge clk);
    n_tests++; if (pf_hits !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL sat_hold got %h want ffffffff", pf_hits);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_cold_miss();
    test_seq_hit();
    test_collision();
    test_wrap();
    test_reset_mid_prefetch();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
